// File: rtl/level_debouncer.sv
// Synchronizer plus four-state debounce FSM for a raw asynchronous level.
// Define LEVEL_DEBOUNCER_GLITCH_CNT_EN to enable the saturating glitch counter.
module level_debouncer #(
   parameter int SYNC_STAGES = 2,
   parameter int DB_CYCLES   = 16,
   parameter int GLITCH_W    = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                rawin,
   output logic                levelout,
   output logic                busy,
   output logic [GLITCH_W-1:0] glitch_cnt
);

   localparam int CNT_W = $clog2(DB_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   localparam logic [1:0] ST_LOW      = 2'd0;
   localparam logic [1:0] ST_CHK_HIGH = 2'd1;
   localparam logic [1:0] ST_HIGH     = 2'd2;
   localparam logic [1:0] ST_CHK_LOW  = 2'd3;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic [1:0]             state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   levelout_q, levelout_d;
   logic                   busy_q, busy_d;

   assign s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], rawin};
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_LOW: begin
            if (s) begin
               if (DB_CYCLES == 1) begin
                  state_d = ST_HIGH;
               end else begin
                  state_d = ST_CHK_HIGH;
                  cnt_d   = CNT_ONE;
               end
            end
         end
         ST_CHK_HIGH: begin
            if (!s) begin
               state_d = ST_LOW;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_HIGH;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_HIGH: begin
            if (!s) begin
               if (DB_CYCLES == 1) begin
                  state_d = ST_LOW;
               end else begin
                  state_d = ST_CHK_LOW;
                  cnt_d   = CNT_ONE;
               end
            end
         end
         ST_CHK_LOW: begin
            if (s) begin
               state_d = ST_HIGH;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_LOW;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = ST_LOW;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs decode the next state so they flip on the same edge as the FSM.
   assign levelout_d = (state_d == ST_HIGH) || (state_d == ST_CHK_LOW);
   assign busy_d     = (state_d == ST_CHK_HIGH) || (state_d == ST_CHK_LOW);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_LOW;
         cnt_q      <= '0;
         levelout_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         levelout_q <= levelout_d;
         busy_q     <= busy_d;
      end
   end

   assign levelout = levelout_q;
   assign busy     = busy_q;

`ifdef LEVEL_DEBOUNCER_GLITCH_CNT_EN
   logic                glitch;
   logic [GLITCH_W-1:0] gcnt_q, gcnt_d;

   assign glitch = ((state_q == ST_CHK_HIGH) && !s) ||
                   ((state_q == ST_CHK_LOW) && s);

   always_comb begin
      gcnt_d = gcnt_q;
      if (glitch && (gcnt_q != '1)) begin
         gcnt_d = gcnt_q + GLITCH_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gcnt_q <= '0;
      end else begin
         gcnt_q <= gcnt_d;
      end
   end

   assign glitch_cnt = gcnt_q;
`else
   assign glitch_cnt = '0;
`endif

endmodule

// File: tb/tb_level_debouncer.sv
// Directed bench for level_debouncer: latency, pulse width, reset, glitch count.
// A second instance covers the single-sample debounce configuration.
module tb_level_debouncer;

`ifdef LEVEL_DEBOUNCER_GLITCH_CNT_EN
   localparam int GEN = 1;
`else
   localparam int GEN = 0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rawin = 1'b0;
   logic       levelout, busy;
   logic [7:0] glitch_cnt;
   logic       rawin1 = 1'b0;
   logic       levelout1, busy1;
   logic [7:0] glitch_cnt1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   level_debouncer dut (
      .clk(clk), .rst(rst), .rawin(rawin),
      .levelout(levelout), .busy(busy),
      .glitch_cnt(glitch_cnt)
   );

   level_debouncer #(.SYNC_STAGES(3), .DB_CYCLES(1)) dut1 (
      .clk(clk), .rst(rst), .rawin(rawin1),
      .levelout(levelout1), .busy(busy1),
      .glitch_cnt(glitch_cnt1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      rawin = 1'b0;
      rawin1 = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   // Ticks n edges; reports first edge where levelout moved and busy stats.
   task automatic run_watch(input int n, output int lvl_edge,
                            output int busy_first, output int busy_n);
      logic l0;
      l0 = levelout;
      lvl_edge = 0;
      busy_first = 0;
      busy_n = 0;
      for (int i = 1; i <= n; i++) begin
         tick();
         if (lvl_edge == 0 && levelout !== l0) lvl_edge = i;
         if (busy === 1'b1) begin
            busy_n++;
            if (busy_first == 0) busy_first = i;
         end
      end
   endtask

   task automatic test_reset();
      int le, bf, bn;
      rst = 1'b0;
      rawin = 1'b1;
      repeat (3) tick();
      checks++;
      if (levelout !== 1'b0) begin
         errors++;
         $display("FAIL rst_levelout got %b want 0", levelout);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL rst_busy got %b want 0", busy);
      end
      checks++;
      if (glitch_cnt !== 8'd0) begin
         errors++;
         $display("FAIL rst_glitch got %0d want 0", glitch_cnt);
      end
      rst = 1'b1;
      run_watch(25, le, bf, bn);
      checks++;
      if (le != 18) begin
         errors++;
         $display("FAIL rise_latency got %0d want 18", le);
      end
      checks++;
      if (bf != 3) begin
         errors++;
         $display("FAIL rise_busy_first got %0d want 3", bf);
      end
      checks++;
      if (bn != 15) begin
         errors++;
         $display("FAIL rise_busy_len got %0d want 15", bn);
      end
   endtask

   task automatic test_fall();
      int le, bf, bn;
      repeat (40) tick();
      checks++;
      if (levelout !== 1'b1) begin
         errors++;
         $display("FAIL hold_high got %b want 1", levelout);
      end
      rawin = 1'b0;
      run_watch(25, le, bf, bn);
      checks++;
      if (le != 18) begin
         errors++;
         $display("FAIL fall_latency got %0d want 18", le);
      end
      checks++;
      if (bf != 3 || bn != 15) begin
         errors++;
         $display("FAIL fall_busy got first %0d len %0d want 3 15", bf, bn);
      end
      checks++;
      if (levelout !== 1'b0) begin
         errors++;
         $display("FAIL fall_level got %b want 0", levelout);
      end
   endtask

   task automatic test_glitch();
      int bn;
      logic hi;
      apply_reset();
      bn = 0;
      hi = 1'b0;
      rawin = 1'b1;
      for (int i = 1; i <= 30; i++) begin
         tick();
         if (i == 5) rawin = 1'b0;
         if (busy === 1'b1) bn++;
         if (levelout !== 1'b0) hi = 1'b1;
      end
      checks++;
      if (hi !== 1'b0) begin
         errors++;
         $display("FAIL glitch_level got high want 0");
      end
      checks++;
      if (bn != 5) begin
         errors++;
         $display("FAIL glitch_busy_len got %0d want 5", bn);
      end
      checks++;
      if (glitch_cnt !== 8'(GEN)) begin
         errors++;
         $display("FAIL glitch_cnt got %0d want %0d", glitch_cnt, GEN);
      end
   endtask

   task automatic test_width();
      int le;
      logic hi;
      apply_reset();
      hi = 1'b0;
      rawin = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (i == 15) rawin = 1'b0;
         if (levelout !== 1'b0) hi = 1'b1;
      end
      checks++;
      if (hi !== 1'b0) begin
         errors++;
         $display("FAIL width15_level got high want 0");
      end
      checks++;
      if (glitch_cnt !== 8'(GEN)) begin
         errors++;
         $display("FAIL width15_cnt got %0d want %0d", glitch_cnt, GEN);
      end
      le = 0;
      rawin = 1'b1;
      for (int i = 1; i <= 30; i++) begin
         tick();
         if (i == 16) rawin = 1'b0;
         if (le == 0 && levelout === 1'b1) le = i;
      end
      checks++;
      if (le != 18) begin
         errors++;
         $display("FAIL width16_edge got %0d want 18", le);
      end
      repeat (30) tick();
      checks++;
      if (levelout !== 1'b0 || glitch_cnt !== 8'(GEN)) begin
         errors++;
         $display("FAIL width16_after got lvl %b cnt %0d want 0 %0d",
                  levelout, glitch_cnt, GEN);
      end
   endtask

   task automatic test_async_reset();
      int le, bf, bn;
      apply_reset();
      rawin = 1'b1;
      repeat (5) tick();
      rawin = 1'b0;
      repeat (10) tick();
      rawin = 1'b1;
      repeat (11) tick();
      checks++;
      if (busy !== 1'b1 || levelout !== 1'b0) begin
         errors++;
         $display("FAIL mid_qual got busy %b lvl %b want 1 0", busy, levelout);
      end
      #3;
      rst = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || levelout !== 1'b0 || glitch_cnt !== 8'd0) begin
         errors++;
         $display("FAIL async_rst got busy %b lvl %b cnt %0d want 0 0 0",
                  busy, levelout, glitch_cnt);
      end
      tick();
      rst = 1'b1;
      run_watch(25, le, bf, bn);
      checks++;
      if (le != 18 || bf != 3 || bn != 15) begin
         errors++;
         $display("FAIL requal got edge %0d first %0d len %0d want 18 3 15",
                  le, bf, bn);
      end
   endtask

   task automatic test_saturate();
      int le, bf, bn;
      apply_reset();
      for (int k = 0; k < 300; k++) begin
         rawin = 1'b1;
         repeat (3) tick();
         rawin = 1'b0;
         repeat (3) tick();
      end
      repeat (10) tick();
      checks++;
      if (glitch_cnt !== 8'(GEN * 255)) begin
         errors++;
         $display("FAIL saturate got %0d want %0d", glitch_cnt, GEN * 255);
      end
      checks++;
      if (levelout !== 1'b0) begin
         errors++;
         $display("FAIL saturate_level got %b want 0", levelout);
      end
      rawin = 1'b1;
      run_watch(25, le, bf, bn);
      checks++;
      if (le != 18) begin
         errors++;
         $display("FAIL post_sat_rise got %0d want 18", le);
      end
   endtask

   task automatic test_db1();
      int re, fe;
      logic bz;
      apply_reset();
      re = 0;
      fe = 0;
      bz = 1'b0;
      rawin1 = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (re == 0 && levelout1 === 1'b1) re = i;
         if (busy1 !== 1'b0) bz = 1'b1;
      end
      rawin1 = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (fe == 0 && levelout1 === 1'b0) fe = i;
         if (busy1 !== 1'b0) bz = 1'b1;
      end
      checks++;
      if (re != 4) begin
         errors++;
         $display("FAIL db1_rise got %0d want 4", re);
      end
      checks++;
      if (fe != 4) begin
         errors++;
         $display("FAIL db1_fall got %0d want 4", fe);
      end
      checks++;
      if (bz !== 1'b0) begin
         errors++;
         $display("FAIL db1_busy got high want 0");
      end
   endtask

   initial begin
      test_reset();
      test_fall();
      test_glitch();
      test_width();
      test_async_reset();
      test_saturate();
      test_db1();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
